// File: rtl/ucode_mul_sequencer.sv
// ucode_mul_sequencer
// Expands a decoded multiply request (muli / mulr) into a stream of native
// 32-bit shift-add micro-ops. The multiplier is scanned LSB first: every set
// bit adds the shifted multiplicand into the scratch accumulator, and the
// multiplicand is shifted left only while set bits remain above the current
// position. The output register follows a valid/ready handshake and holds its
// word stable while stalled.
module ucode_mul_sequencer #(
  parameter logic [3:0] SCR_ACC   = 4'd14,
  parameter logic [3:0] SCR_T     = 4'd15,
  parameter logic [2:0] ALU_ADD   = 3'b001,
  parameter logic [2:0] ALU_AND   = 3'b011,
  parameter logic [2:0] ALU_SHL   = 3'b101,
  parameter int         MULT_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_trigger,
  input  logic        mul_type,
  input  logic [3:0]  dest_reg,
  input  logic [3:0]  src1_reg,
  input  logic [3:0]  src2_reg,
  input  logic [15:0] imm,
  output logic        busy,
  output logic        rf_rd_en,
  output logic [3:0]  rf_rd_addr,
  input  logic [31:0] rf_rd_data,
  output logic        uop_valid,
  output logic [31:0] uop_instr,
  input  logic        uop_ready,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RDREG  = 3'd1,
    ST_WAITRD = 3'd2,
    ST_COPY   = 3'd3,
    ST_CLR    = 3'd4,
    ST_STEP   = 3'd5,
    ST_FIN    = 3'd6
  } state_t;

  localparam logic [1:0] PICK_ADD = 2'd0;
  localparam logic [1:0] PICK_SHL = 2'd1;
  localparam logic [1:0] PICK_FIN = 2'd2;

  // Data-immediate format: class 00, src2 field unused, imm in [15:0].
  function automatic logic [31:0] enc_imm(input logic [2:0] alu, input logic [3:0] dst,
                                          input logic [3:0] s1, input logic [15:0] im);
    enc_imm = {2'b00, 1'b0, 1'b0, alu, dst, s1, 1'b0, im};
  endfunction

  // Data-register format: class 01, low 13 bits zero.
  function automatic logic [31:0] enc_reg(input logic [2:0] alu, input logic [3:0] dst,
                                          input logic [3:0] s1, input logic [3:0] s2);
    enc_reg = {2'b01, 1'b0, 1'b0, alu, dst, s1, s2, 13'd0};
  endfunction

  // Decide what a fresh bit position emits: ADD if its bit is set, a bare SHL
  // if only higher bits remain, otherwise the sequence is finished.
  function automatic logic [1:0] step_pick(input logic [MULT_BITS-1:0] v);
    if (v[0]) begin
      step_pick = PICK_ADD;
    end else if (v[MULT_BITS-1:1] != {(MULT_BITS-1){1'b0}}) begin
      step_pick = PICK_SHL;
    end else begin
      step_pick = PICK_FIN;
    end
  endfunction

  // State and datapath registers
  state_t               r_state;
  logic [3:0]           r_dest;
  logic [3:0]           r_src1;
  logic [MULT_BITS-1:0] r_mrem;       // multiplier shifted right by the current bit index
  logic                 r_step_shl;   // STEP sub-phase: 0 = ADD presented, 1 = SHL presented
  logic                 r_uop_valid;
  logic [31:0]          r_uop_instr;
  logic                 r_done;
  logic                 r_busy;
  logic                 r_rf_rd_en;
  logic [3:0]           r_rf_rd_addr;

  // Next-state wires
  state_t               w_state_nxt;
  logic [3:0]           w_dest_nxt;
  logic [3:0]           w_src1_nxt;
  logic [MULT_BITS-1:0] w_mrem_nxt;
  logic                 w_step_shl_nxt;
  logic                 w_uop_valid_nxt;
  logic [31:0]          w_uop_instr_nxt;
  logic                 w_done_nxt;
  logic                 w_rf_rd_en_nxt;
  logic [3:0]           w_rf_rd_addr_nxt;

  // Fresh-position decision shared by CLR and post-SHL transitions
  logic [MULT_BITS-1:0] w_fresh_v;
  state_t               w_fresh_state;
  logic                 w_fresh_shl;
  logic [31:0]          w_fresh_instr;

  logic                 w_accept;
  logic [31:0]          w_uop_clr;
  logic [31:0]          w_uop_add;
  logic [31:0]          w_uop_shl;
  logic [31:0]          w_uop_fin;
  logic                 w_rd_hi_unused;

  assign w_accept  = r_uop_valid & uop_ready;
  assign w_uop_clr = enc_imm(ALU_AND, SCR_ACC, SCR_ACC, 16'd0);
  assign w_uop_add = enc_reg(ALU_ADD, SCR_ACC, SCR_ACC, SCR_T);
  assign w_uop_shl = enc_imm(ALU_SHL, SCR_T, SCR_T, 16'd1);
  assign w_uop_fin = enc_imm(ALU_ADD, r_dest, SCR_ACC, 16'd0);

  // Only the low multiplier bits of the register read are meaningful.
  assign w_rd_hi_unused = ^rf_rd_data[31:MULT_BITS];

  // Pick the first uop of the next bit position (after CLR, or after a SHL).
  always_comb begin
    w_fresh_state = ST_FIN;
    w_fresh_shl   = 1'b0;
    w_fresh_instr = w_uop_fin;
    if (r_state == ST_STEP) begin
      w_fresh_v = {1'b0, r_mrem[MULT_BITS-1:1]};
    end else begin
      w_fresh_v = r_mrem;
    end
    case (step_pick(w_fresh_v))
      PICK_ADD: begin
        w_fresh_state = ST_STEP;
        w_fresh_shl   = 1'b0;
        w_fresh_instr = w_uop_add;
      end
      PICK_SHL: begin
        w_fresh_state = ST_STEP;
        w_fresh_shl   = 1'b1;
        w_fresh_instr = w_uop_shl;
      end
      default: begin
        w_fresh_state = ST_FIN;
        w_fresh_shl   = 1'b0;
        w_fresh_instr = w_uop_fin;
      end
    endcase
  end

  // Next-state and output-register logic for the sequencer FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_dest_nxt       = r_dest;
    w_src1_nxt       = r_src1;
    w_mrem_nxt       = r_mrem;
    w_step_shl_nxt   = r_step_shl;
    w_uop_valid_nxt  = r_uop_valid;
    w_uop_instr_nxt  = r_uop_instr;
    w_done_nxt       = 1'b0;
    w_rf_rd_en_nxt   = 1'b0;
    w_rf_rd_addr_nxt = 4'd0;

    case (r_state)
      ST_IDLE: begin
        if (mul_trigger) begin
          w_dest_nxt = dest_reg;
          w_src1_nxt = src1_reg;
          if (mul_type) begin
            w_state_nxt      = ST_RDREG;
            w_rf_rd_en_nxt   = 1'b1;
            w_rf_rd_addr_nxt = src2_reg;
          end else begin
            w_state_nxt     = ST_COPY;
            w_mrem_nxt      = imm[MULT_BITS-1:0];
            w_uop_valid_nxt = 1'b1;
            w_uop_instr_nxt = enc_imm(ALU_ADD, SCR_T, src1_reg, 16'd0);
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_RDREG: begin
        w_state_nxt = ST_WAITRD;
      end

      ST_WAITRD: begin
        w_state_nxt     = ST_COPY;
        w_mrem_nxt      = rf_rd_data[MULT_BITS-1:0];
        w_uop_valid_nxt = 1'b1;
        w_uop_instr_nxt = enc_imm(ALU_ADD, SCR_T, r_src1, 16'd0);
      end

      ST_COPY: begin
        if (w_accept) begin
          w_state_nxt     = ST_CLR;
          w_uop_instr_nxt = w_uop_clr;
        end else begin
          w_state_nxt = ST_COPY;
        end
      end

      ST_CLR: begin
        if (w_accept) begin
          w_state_nxt     = w_fresh_state;
          w_step_shl_nxt  = w_fresh_shl;
          w_uop_instr_nxt = w_fresh_instr;
        end else begin
          w_state_nxt = ST_CLR;
        end
      end

      ST_STEP: begin
        if (w_accept) begin
          if (!r_step_shl) begin
            // ADD taken; shift only if set bits remain above this position.
            if (r_mrem[MULT_BITS-1:1] != {(MULT_BITS-1){1'b0}}) begin
              w_state_nxt     = ST_STEP;
              w_step_shl_nxt  = 1'b1;
              w_uop_instr_nxt = w_uop_shl;
            end else begin
              w_state_nxt     = ST_FIN;
              w_step_shl_nxt  = 1'b0;
              w_uop_instr_nxt = w_uop_fin;
            end
          end else begin
            // SHL taken; move to the next bit position.
            w_mrem_nxt      = {1'b0, r_mrem[MULT_BITS-1:1]};
            w_state_nxt     = w_fresh_state;
            w_step_shl_nxt  = w_fresh_shl;
            w_uop_instr_nxt = w_fresh_instr;
          end
        end else begin
          w_state_nxt = ST_STEP;
        end
      end

      ST_FIN: begin
        if (w_accept) begin
          w_state_nxt     = ST_IDLE;
          w_uop_valid_nxt = 1'b0;
          w_uop_instr_nxt = 32'd0;
          w_done_nxt      = 1'b1;
          w_mrem_nxt      = {MULT_BITS{1'b0}};
          w_step_shl_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_FIN;
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_uop_valid_nxt = 1'b0;
        w_uop_instr_nxt = 32'd0;
      end
    endcase
  end

  // State and registered-output update with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_dest       <= 4'd0;
      r_src1       <= 4'd0;
      r_mrem       <= {MULT_BITS{1'b0}};
      r_step_shl   <= 1'b0;
      r_uop_valid  <= 1'b0;
      r_uop_instr  <= 32'd0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_rf_rd_en   <= 1'b0;
      r_rf_rd_addr <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_dest       <= w_dest_nxt;
      r_src1       <= w_src1_nxt;
      r_mrem       <= w_mrem_nxt;
      r_step_shl   <= w_step_shl_nxt;
      r_uop_valid  <= w_uop_valid_nxt;
      r_uop_instr  <= w_uop_instr_nxt;
      r_done       <= w_done_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_rf_rd_en   <= w_rf_rd_en_nxt;
      r_rf_rd_addr <= w_rf_rd_addr_nxt;
    end
  end

  assign busy       = r_busy;
  assign rf_rd_en   = r_rf_rd_en;
  assign rf_rd_addr = r_rf_rd_addr;
  assign uop_valid  = r_uop_valid;
  assign uop_instr  = r_uop_instr;
  assign done       = r_done;

endmodule

// File: tb/tb_ucode_mul_sequencer.sv
// Directed bench for ucode_mul_sequencer: each multiply is expanded from its
// multiplier bits into the expected uop list, and every accepted uop, the
// register-read strobe, done/busy timing and stall stability are checked.
module tb_ucode_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mul_trigger;
  logic        mul_type;
  logic [3:0]  dest_reg;
  logic [3:0]  src1_reg;
  logic [3:0]  src2_reg;
  logic [15:0] imm;
  logic        busy;
  logic        rf_rd_en;
  logic [3:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        uop_valid;
  logic [31:0] uop_instr;
  logic        uop_ready;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];

  // Fixed words, hand-encoded from the field layout.
  localparam logic [31:0] CLR_W = 32'h07DC_0000;  // and r14 <- r14, #0
  localparam logic [31:0] ADD_W = 32'h43DD_E000;  // add r14 <- r14, r15
  localparam logic [31:0] SHL_W = 32'h0BFE_0001;  // shl r15 <- r15, #1

  ucode_mul_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .mul_trigger(mul_trigger),
    .mul_type   (mul_type),
    .dest_reg   (dest_reg),
    .src1_reg   (src1_reg),
    .src2_reg   (src2_reg),
    .imm        (imm),
    .busy       (busy),
    .rf_rd_en   (rf_rd_en),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .uop_valid  (uop_valid),
    .uop_instr  (uop_instr),
    .uop_ready  (uop_ready),
    .done       (done)
  );

  always #5 clk = ~clk;

  // add r15 <- rs, #0
  function automatic logic [31:0] copy_w(input logic [3:0] rs);
    return 32'h03E0_0000 | ({28'd0, rs} << 17);
  endfunction

  // add rd <- r14, #0
  function automatic logic [31:0] fin_w(input logic [3:0] rd);
    return 32'h021C_0000 | ({28'd0, rd} << 21);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic build_exp(input logic [3:0] rd, input logic [3:0] rs, input logic [15:0] m);
    int hi;
    exp_q.delete();
    exp_q.push_back(copy_w(rs));
    exp_q.push_back(CLR_W);
    hi = -1;
    for (int i = 0; i < 16; i++) if (m[i]) hi = i;
    for (int i = 0; i <= hi; i++) begin
      if (m[i]) exp_q.push_back(ADD_W);
      if (i < hi) exp_q.push_back(SHL_W);
    end
    exp_q.push_back(fin_w(rd));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " busy"},       {31'd0, busy},       32'd0);
    chk({tag, " rf_rd_en"},   {31'd0, rf_rd_en},   32'd0);
    chk({tag, " rf_rd_addr"}, {28'd0, rf_rd_addr}, 32'd0);
    chk({tag, " uop_valid"},  {31'd0, uop_valid},  32'd0);
    chk({tag, " uop_instr"},  uop_instr,           32'd0);
    chk({tag, " done"},       {31'd0, done},       32'd0);
  endtask

  // Run one multiply from trigger to done. mode 0 = ready always high,
  // mode 1 = fixed stall pattern. mid = pulse a stray trigger mid-sequence.
  task automatic run_seq(input string tag, input logic typ, input logic [3:0] rd,
                         input logic [3:0] rs, input logic [3:0] rt, input logic [15:0] im,
                         input logic [31:0] rdata, input int mode, input bit mid,
                         input int n_expect);
    logic [15:0] m;
    logic [31:0] held;
    logic [15:0] pat;
    int idx, gaps, rd_cnt;
    bit stalled, got_done;
    m = typ ? rdata[15:0] : im;
    build_exp(rd, rs, m);
    pat = 16'b1001_0110_1100_1001;

    @(negedge clk);
    mul_trigger = 1'b1; mul_type = typ;
    dest_reg = rd; src1_reg = rs; src2_reg = rt; imm = im;
    uop_ready = (mode == 0);
    @(negedge clk);
    mul_trigger = 1'b0;
    dest_reg = ~rd; src1_reg = ~rs; src2_reg = ~rt; imm = ~im;
    chk({tag, " busy rise"}, {31'd0, busy}, 32'd1);
    rd_cnt = rf_rd_en ? 1 : 0;
    if (typ) begin
      chk({tag, " rd_addr"}, {28'd0, rf_rd_addr}, {28'd0, rt});
      @(negedge clk);
      chk({tag, " rd_en one cycle"}, {31'd0, rf_rd_en}, 32'd0);
      rf_rd_data = rdata;
      @(negedge clk);
      rf_rd_data = 32'hDEAD_BEEF;
    end

    idx = 0; gaps = 0; stalled = 1'b0; got_done = 1'b0; held = 32'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (rf_rd_en) rd_cnt++;
      mul_trigger = mid && (cyc == 3);
      if (mid && cyc == 3) begin
        mul_type = 1'b1; src2_reg = 4'd9; dest_reg = 4'd1; imm = 16'h1111;
      end
      if (stalled) chk({tag, " hold"}, uop_instr, held);
      if (!uop_valid) gaps++;
      uop_ready = (mode == 0) ? 1'b1 : pat[cyc % 16];
      if (uop_valid && uop_ready) begin
        if (idx < exp_q.size()) chk($sformatf("%s uop%0d", tag, idx), uop_instr, exp_q[idx]);
        idx++;
      end
      stalled = uop_valid && !uop_ready;
      held = uop_instr;
      @(negedge clk);
    end
    mul_trigger = 1'b0;
    chk({tag, " done seen"}, {31'd0, got_done}, 32'd1);
    chk({tag, " uop count"}, idx, n_expect);
    chk({tag, " busy at done"}, {31'd0, busy}, 32'd0);
    chk({tag, " valid at done"}, {31'd0, uop_valid}, 32'd0);
    chk({tag, " rf reads"}, rd_cnt, {31'd0, typ});
    if (mode == 0) chk({tag, " gaps"}, gaps, 32'd0);
    @(negedge clk);
    chk({tag, " done pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; mul_trigger = 1'b0; mul_type = 1'b0;
    dest_reg = 4'd0; src1_reg = 4'd0; src2_reg = 4'd0; imm = 16'd0;
    rf_rd_data = 32'd0; uop_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("idle");

    // 5 = bits 0,2: COPY CLR ADD SHL SHL ADD FIN
    run_seq("muli5", 1'b0, 4'd3, 4'd2, 4'd0, 16'h0005, 32'd0, 0, 1'b0, 7);
    run_seq("muli0", 1'b0, 4'd1, 4'd4, 4'd0, 16'h0000, 32'd0, 0, 1'b0, 3);
    // COPY, CLR, 15 SHL, ADD, FIN
    run_seq("muli8000", 1'b0, 4'd6, 4'd5, 4'd0, 16'h8000, 32'd0, 0, 1'b0, 19);
    // M = 3: COPY CLR ADD SHL ADD FIN; upper read bits ignored
    run_seq("mulr3", 1'b1, 4'd4, 4'd8, 4'd7, 16'hFFFF, 32'h0001_0003, 0, 1'b0, 6);
    // 0xB7: popcount 6, top bit 7
    run_seq("stallB7", 1'b0, 4'd2, 4'd3, 4'd0, 16'h00B7, 32'd0, 1, 1'b0, 16);
    // 0x0A00 via register with stalls: popcount 2, top bit 11
    run_seq("mulrA00", 1'b1, 4'd0, 4'd1, 4'd12, 16'd0, 32'hFFFF_0A00, 1, 1'b0, 16);
    // stray trigger mid-sequence ignored; 0x13: popcount 3, top bit 4
    run_seq("midtrig", 1'b0, 4'd7, 4'd6, 4'd0, 16'h0013, 32'd0, 0, 1'b1, 10);
    // rs is the accumulator itself
    run_seq("rsacc", 1'b0, 4'd9, 4'd14, 4'd0, 16'h0006, 32'd0, 0, 1'b0, 7);
    // worst case: popcount 16, top bit 15
    run_seq("mulFFFF", 1'b0, 4'd10, 4'd11, 4'd0, 16'hFFFF, 32'd0, 1, 1'b0, 34);

    // Asynchronous reset while a STEP uop is presented.
    @(negedge clk);
    uop_ready = 1'b1; mul_trigger = 1'b1; mul_type = 1'b0;
    dest_reg = 4'd5; src1_reg = 4'd6; imm = 16'hFFFF;
    @(negedge clk);
    mul_trigger = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-reset valid", {31'd0, uop_valid}, 32'd1);
    #2 rst = 1'b0;
    #1 check_all_zero("async reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post-reset busy", {31'd0, busy}, 32'd0);
    chk("post-reset valid", {31'd0, uop_valid}, 32'd0);
    // 0x0101: popcount 2, top bit 8
    run_seq("after_rst", 1'b0, 4'd2, 4'd1, 4'd0, 16'h0101, 32'd0, 0, 1'b0, 13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
